// File: rtl/idct_feed_ctrl_pkg.sv
// Shared parameters, state encoding and timing constants for the IDCT feed sequencer.
// IDCT_FEED_MARKER_EN adds a per-lane header word and shifts the result window by one cycle.
package idct_pkg;

  localparam int DW        = 16;
  localparam int N         = 4;
  localparam int ROWS      = 4;
  localparam int OW        = 24;
  localparam int ARRAY_LAT = 4;
  localparam int OUT_BEATS = 4;

  localparam logic [DW-1:0] IDCT_MARKER = 16'd1;

`ifdef IDCT_FEED_MARKER_EN
  localparam int FEED_LEN  = ROWS + N;
  localparam int WIN_START = ARRAY_LAT + 1;
`else
  localparam int FEED_LEN  = ROWS + N - 1;
  localparam int WIN_START = ARRAY_LAT;
`endif

  localparam int WIN_END = WIN_START + OUT_BEATS;
  localparam int RW      = $clog2(ROWS);
  localparam int FW      = $clog2(FEED_LEN);
  localparam int TW      = $clog2(WIN_END + 1);

  typedef enum logic [1:0] {IDLE, LOAD, FEED, DRAIN} state_e;

endpackage

// File: rtl/idct_feed_ctrl_if.sv
// Row input stream and qualified result stream of the IDCT feed sequencer.
interface idct_feed_ctrl_if;
  import idct_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_row;
  logic [OW-1:0]   out_data;
  logic            out_valid;
  logic            out_last;

  modport master (output in_valid, in_row, input in_ready, out_data, out_valid, out_last);
  modport slave  (input in_valid, in_row, output in_ready, out_data, out_valid, out_last);

endinterface

// File: rtl/idct_feed_ctrl_lane_skew.sv
// One array lane: picks the buffered row for this lane's skewed time slot and registers it.
// IDCT_FEED_MARKER_EN inserts IDCT_MARKER at t=K and delays the data by one slot.
module idct_lane_skew
  import idct_pkg::*;
#(
  parameter int K = 0
)
(
  input  logic          clk,
  input  logic          reset,
  input  logic          active,
  input  logic [FW-1:0] t,
  input  logic [DW-1:0] col [ROWS],
  output logic [DW-1:0] d_out
);

  localparam logic [FW:0] K_EXT = (FW+1)'(K);

  // Extra top bit flags t < K so no compare degenerates to a constant for lane 0.
  logic [FW:0]   dif;
  logic [DW-1:0] sel;

  always_comb begin
    sel = '0;
    dif = {1'b0, t} - K_EXT;
`ifdef IDCT_FEED_MARKER_EN
    if (dif == '0)
      sel = IDCT_MARKER;
    else if (!dif[FW] && (dif[FW-1:0] <= FW'(ROWS)))
      sel = col[RW'(dif[FW-1:0] - FW'(1))];
`else
    if (!dif[FW] && (dif[FW-1:0] < FW'(ROWS)))
      sel = col[dif[RW-1:0]];
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) d_out <= '0;
    else        d_out <= active ? sel : '0;
  end

endmodule

// File: rtl/idct_feed_ctrl.sv
// Buffers a 4x4 coefficient block, feeds it diagonally skewed into the systolic array
// and qualifies the array result window. IDCT_FEED_MARKER_EN selects the header-word variant.
//
//  state | meaning
//  IDLE  | waiting for the first row of a block
//  LOAD  | collecting rows 1..ROWS-1 into the buffer
//  FEED  | driving skewed lanes, one feed slot per cycle
//  DRAIN | feed done, waiting for the last result beat
module idct_feed_ctrl
  import idct_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  idct_feed_ctrl_if.slave     bus,
  output logic [DW-1:0]       d_in_1,
  output logic [DW-1:0]       d_in_2,
  output logic [DW-1:0]       d_in_3,
  output logic [DW-1:0]       d_in_4,
  output logic                feed_valid,
  input  logic [OW-1:0]       arr_dout,
  output logic                busy
);

  state_e          state_q, state_d;
  logic [RW-1:0]   row_cnt;
  logic [FW-1:0]   fcnt;
  logic [TW-1:0]   tcnt;
  logic [N*DW-1:0] row_buf [ROWS];

  logic in_ready_c, busy_c, accept, feeding, running, feed_last, in_win, win_last;

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    busy_c     = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b0;
        if (bus.in_valid) state_d = LOAD;
      end
      LOAD: begin
        in_ready_c = 1'b1;
        if (bus.in_valid && (row_cnt == RW'(ROWS-1))) state_d = FEED;
      end
      FEED:    if (feed_last) state_d = DRAIN;
      DRAIN:   if (bus.out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready = in_ready_c;
  assign busy         = busy_c;
  assign accept       = bus.in_valid && in_ready_c;
  assign feeding      = (state_q == FEED);
  assign running      = (state_q == FEED) || (state_q == DRAIN);
  assign feed_last    = (fcnt == FW'(FEED_LEN-1));
  // tcnt of this cycle becomes the output-side slot index after the register stage.
  assign in_win       = (tcnt >= TW'(WIN_START)) && (tcnt < TW'(WIN_END));
  assign win_last     = (tcnt == TW'(WIN_END-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      row_cnt       <= '0;
      fcnt          <= '0;
      tcnt          <= '0;
      feed_valid    <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= '0;
      for (int i = 0; i < ROWS; i++) row_buf[i] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        row_buf[row_cnt] <= bus.in_row;
        row_cnt          <= (row_cnt == RW'(ROWS-1)) ? '0 : row_cnt + RW'(1);
      end
      fcnt          <= (feeding && !feed_last) ? fcnt + FW'(1) : '0;
      tcnt          <= running ? tcnt + TW'(1) : '0;
      feed_valid    <= feeding;
      bus.out_valid <= running && in_win;
      bus.out_last  <= running && win_last;
      bus.out_data  <= (running && in_win) ? arr_dout : '0;
    end
  end

  logic [DW-1:0] lane_col [N][ROWS];
  logic [DW-1:0] lane_out [N];

  for (genvar k = 0; k < N; k++) begin : g_lane
    for (genvar r = 0; r < ROWS; r++) begin : g_col
      assign lane_col[k][r] = row_buf[r][k*DW +: DW];
    end
    idct_lane_skew #(.K(k)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .active (feeding),
      .t      (fcnt),
      .col    (lane_col[k]),
      .d_out  (lane_out[k])
    );
  end

  assign d_in_1 = lane_out[0];
  assign d_in_2 = lane_out[1];
  assign d_in_3 = lane_out[2];
  assign d_in_4 = lane_out[3];

endmodule

// File: tb/tb_idct_feed_ctrl.sv
// Scoreboard bench for idct_feed_ctrl: directed blocks, back-to-back stall and mid-block reset.
// Expectations follow IDCT_FEED_MARKER_EN when it is defined.
module tb_idct_feed_ctrl;
  import idct_pkg::*;

`ifdef IDCT_FEED_MARKER_EN
  localparam int WS = 5, FL = 8, STALL = 10;
`else
  localparam int WS = 4, FL = 7, STALL = 9;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] d_in_1, d_in_2, d_in_3, d_in_4;
  logic          feed_valid, busy;
  logic [OW-1:0] arr_dout = '0;

  idct_feed_ctrl_if bus();

  idct_feed_ctrl dut (
    .clk(clk), .reset(reset), .bus(bus),
    .d_in_1(d_in_1), .d_in_2(d_in_2), .d_in_3(d_in_3), .d_in_4(d_in_4),
    .feed_valid(feed_valid), .arr_dout(arr_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0, last_cyc = -1, acc_cyc = -1;
  logic [63:0] lane_q [$];
  logic [24:0] out_q [$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [63:0] exp_lanes(input int t);
    logic [63:0] v;
`ifdef IDCT_FEED_MARKER_EN
    int l [4];
    for (int k = 0; k < 4; k++) begin
      if (t == k) l[k] = 1;
      else if (t > k && t - k <= 4) l[k] = 4 * (t - k - 1) + k + 1;
      else l[k] = 0;
    end
    v = pk(l[0], l[1], l[2], l[3]);
`else
    case (t)
      0:       v = pk( 1,  0,  0,  0);
      1:       v = pk( 5,  2,  0,  0);
      2:       v = pk( 9,  6,  3,  0);
      3:       v = pk(13, 10,  7,  4);
      4:       v = pk( 0, 14, 11,  8);
      5:       v = pk( 0,  0, 15, 12);
      default: v = pk( 0,  0,  0, 16);
    endcase
`endif
    return v;
  endfunction

  function automatic logic [63:0] row_val(input int r);
    return pk(4*r+1, 4*r+2, 4*r+3, 4*r+4);
  endfunction

  // Monitor: pops one expectation whenever the DUT presents a lane slot or a result beat.
  always @(negedge clk) begin
    if (feed_valid) begin
      if (lane_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL lanes_extra: got %0h expected no feed slot", {d_in_4, d_in_3, d_in_2, d_in_1});
      end else chk("lanes", {d_in_4, d_in_3, d_in_2, d_in_1}, lane_q.pop_front());
    end
    if (bus.out_valid) begin
      if (out_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_extra: got %0h expected no result beat", bus.out_data);
      end else chk("out_beat", 64'({bus.out_last, bus.out_data}), 64'(out_q.pop_front()));
      if (bus.out_last) last_cyc = cyc;
    end
  end

  task automatic push_block();
    for (int t = 0; t < FL; t++) lane_q.push_back(exp_lanes(t));
    for (int j = 0; j < 4; j++) out_q.push_back({j == 3, OW'(100 + WS + j)});
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send_row(input logic [N*DW-1:0] row, output int stall);
    stall = 0;
    bus.in_valid = 1'b1;
    bus.in_row   = row;
    while (!bus.in_ready && stall < 50) begin
      @(negedge clk);
      stall++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL row_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    acc_cyc = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drive_arr(input int n);
    for (int k = 0; k < n; k++) begin
      arr_dout = OW'(100 + k);
      @(negedge clk);
    end
  endtask

  task automatic send_block();
    int s;
    push_block();
    for (int r = 0; r < ROWS; r++) send_row(row_val(r), s);
  endtask

  initial begin
    int s;
    bus.in_valid = 1'b0;
    bus.in_row   = '0;
    repeat (3) @(negedge clk);

    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_busy",     64'(busy), 64'(0));
    chk("rst_d_in",     {d_in_4, d_in_3, d_in_2, d_in_1}, 64'(0));
    chk("rst_out",      64'({bus.out_valid, bus.out_last, feed_valid, bus.out_data}), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    chk("idle_ready", 64'({bus.in_ready, busy}), 64'(2'b10));

    // Block A: plain pattern and result window
    send_block();
    chk("feed_busy", 64'({bus.in_ready, busy}), 64'(2'b01));
    drive_arr(12);
    chk("back_idle", 64'({bus.in_ready, busy}), 64'(2'b10));

    // Block B held valid into block C: stall through FEED/DRAIN
    push_block();
    for (int r = 0; r < ROWS; r++) send_row(row_val(r), s);
    push_block();
    fork
      drive_arr(12);
      begin
        send_row(row_val(0), s);
        chk("stall_len", 64'(s), 64'(STALL));
        chk("accept_after_last", 64'(acc_cyc), 64'(last_cyc + 1));
      end
    join
    for (int r = 1; r < ROWS; r++) send_row(row_val(r), s);
    drive_arr(12);

    // Block D aborted by reset in slot t=3
    send_block();
    drive_arr(4);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_d_in", {d_in_4, d_in_3, d_in_2, d_in_1}, 64'(0));
    chk("mid_rst_ctl",  64'({bus.out_valid, bus.out_last, feed_valid, busy, bus.in_ready}), 64'(1));
    lane_q.delete();
    out_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Block E: full pattern after reset
    send_block();
    drive_arr(12);

    chk("lane_q_left", 64'(lane_q.size()), 64'(0));
    chk("out_q_left",  64'(out_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
